rr_arith_scheduler: RTL and testbench
=====================================

Name: rr_arith_scheduler

Overview:
- Time-shares one reconfigurable-region arithmetic unit among NUM_REQ requesters using round-robin arbitration.
- The unit has a 4-bit registered datapath with fixed LATENCY, e.g. a registered decrementer.
- Tracks the in-flight operation, returns each result tagged to its originator, and gates the unit for partial reconfiguration.
- Drains in-flight work, isolates the unit, and resumes on reconfiguration complete.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 4, operand/result width.
- LATENCY, 1, clock edges from unit_data valid to unit_result valid.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-requester request level; held until grant.
- req_data  in  NUM_REQ*DATA_W  operands; requester i occupies bits [i*DATA_W +: DATA_W].
- grant  out  NUM_REQ  one-hot, one-cycle pulse; operand consumed.
- rsp_valid  out  NUM_REQ  one-hot, one-cycle pulse; rsp_data valid for that requester.
- rsp_data  out  DATA_W  result, registered.
- unit_data  out  DATA_W  operand to arithmetic unit, registered.
- unit_result  in  DATA_W  registered result from arithmetic unit.
- rc_req  in  1  reconfiguration request, level.
- rc_ready  out  1  unit idle and isolated; safe to reconfigure.
- rc_done  in  1  one-cycle pulse: reconfiguration finished.

Behaviour:
- Reset values:
  - grant=0, rsp_valid=0, rsp_data=0, unit_data=0, rc_ready=0.
  - State=IDLE, rr pointer=NUM_REQ-1, so requester 0 wins first.
  - Latency counter=0, tag=0.
- States: IDLE, BUSY, RECONFIG.
- IDLE:
  - If rc_req=1: go to RECONFIG and set rc_ready=1 at that edge. rc_req has priority over pending req.
  - Else if any req: winner = first asserted index searching ptr+1, ptr+2, … modulo NUM_REQ. At the edge:
    - grant[winner]=1 for one cycle.
    - unit_data<=req_data[winner]; tag<=winner; ptr<=winner.
    - cnt<=LATENCY; go to BUSY.
  - Else: hold; grant=0.
- BUSY:
  - While cnt!=0, decrement each edge. No grants. rc_req ignored.
  - When cnt==0, at the edge: rsp_data<=unit_result, rsp_valid[tag]=1 for one cycle, go to IDLE.
  - A new grant is possible the following edge.
- Timing with LATENCY=1:
  - grant edge E0; unit registers at E1; rsp edge E2.
  - Throughput one operation per 3 cycles under continuous requests.
  - General latency grant-to-rsp = LATENCY+1 edges.
- RECONFIG:
  - rc_ready=1, unit_data forced 0, unit_result ignored, no grants, req held pending.
  - On rc_done=1: rc_ready<=0, go to IDLE.
  - rc_done outside RECONFIG is ignored.
  - If rc_req is still 1 when returning to IDLE, RECONFIG is re-entered next edge.
- Arithmetic: the scheduler performs none. rsp_data is unit_result verbatim, DATA_W bits, wrap-around is the unit's.
- Requester deasserting req before grant: no grant issued; arbitration uses the current cycle's req only.
- Requester may re-request after its grant, before its rsp. It is arbitrated normally but cannot be granted until the current op returns (single in-flight op).
- rst mid-BUSY: in-flight operation dropped, no rsp_valid emitted, all outputs to reset values next edge.
- rst mid-RECONFIG: rc_ready drops to 0; the environment must re-request.
- Invariants:
  - At most one bit of grant set; at most one bit of rsp_valid set.
  - grant and rsp_valid never both nonzero in the same cycle.
  - rc_ready never 1 while an op is in flight.

Test Plan:
- Single op:
  - Stimulus: req[0]=1, req_data[0]=5, unit = decrementer.
  - Required: grant=0001 at E0, unit_data=5, rsp_valid=0001 with rsp_data=4 at E2.
- Wrap-around:
  - Stimulus: req[2], data 0.
  - Required: rsp_valid=0100, rsp_data=15.
- Round-robin fairness:
  - Stimulus: all four req held, data 1,2,3,4.
  - Required: grants 0,1,2,3,0 every 3 cycles; responses 0,1,2,3 in the same order, each tagged to its grant.
- Reconfig during BUSY:
  - Stimulus: grant req1 (data 9), raise rc_req next cycle.
  - Required: rsp_valid[1] with 8 still emitted; then rc_ready=1, unit_data=0.
  - Stimulus: req0 pending, then rc_done pulse.
  - Required: no grant during RECONFIG; rc_ready=0, then grant[0].
- Reset mid-op:
  - Stimulus: assert rst the cycle after grant[3].
  - Required: no rsp_valid; all outputs 0; after release, req0 and req3 both pending grants req0 first.
- Priority:
  - Stimulus: rc_req and req[1] rise in the same IDLE cycle.
  - Required: RECONFIG entered, no grant until after rc_done.

Source files
------------

// File: rtl/rr_arith_if.sv
// Bundle between the requesters/reconfiguration controller and the
// round-robin scheduler that fronts the shared arithmetic unit.
interface rr_arith_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 4
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        grant;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_data;
  logic [DATA_W-1:0]         unit_data;
  logic [DATA_W-1:0]         unit_result;
  logic                      rc_req;
  logic                      rc_ready;
  logic                      rc_done;

  // Environment side: requesters, arithmetic unit and reconfiguration controller.
  modport master (
    output req, req_data, unit_result, rc_req, rc_done,
    input  grant, rsp_valid, rsp_data, unit_data, rc_ready
  );

  // Scheduler side.
  modport slave (
    input  req, req_data, unit_result, rc_req, rc_done,
    output grant, rsp_valid, rsp_data, unit_data, rc_ready
  );
endinterface

// File: rtl/rr_arith_scheduler.sv
// Round-robin scheduler time-sharing one registered arithmetic unit among
// NUM_REQ requesters. Single operation in flight; the result is returned
// tagged to its originator. The unit can be drained and isolated for
// partial reconfiguration and is resumed on rc_done.
module rr_arith_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 4,
  parameter int LATENCY = 1
) (
  input  logic     clk,
  input  logic     rst,
  rr_arith_if.slave bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BUSY     = 2'd1,
    RECONFIG = 2'd2
  } state_t;

  state_t              state_reg, state_next;
  logic [IDX_W-1:0]    ptr_reg, ptr_next;
  logic [IDX_W-1:0]    tag_reg, tag_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic [NUM_REQ-1:0]  grant_reg, grant_next;
  logic [NUM_REQ-1:0]  rsp_valid_reg, rsp_valid_next;
  logic [DATA_W-1:0]   rsp_data_reg, rsp_data_next;
  logic [DATA_W-1:0]   unit_data_reg, unit_data_next;
  logic                rc_ready_reg, rc_ready_next;

  logic [DATA_W-1:0]   operand [NUM_REQ];
  logic                win_found;
  logic [IDX_W-1:0]    win_idx;
  int                  cand;

  // Unpack the flat operand bus into one word per requester.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_operand
      assign operand[gi] = bus.req_data[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // Round-robin search: first asserted request after the last winner.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(ptr_reg) + k) % NUM_REQ;
      if (!win_found && bus.req[IDX_W'(cand)]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(cand);
      end
    end
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_next     = state_reg;
    ptr_next       = ptr_reg;
    tag_next       = tag_reg;
    cnt_next       = cnt_reg;
    grant_next     = '0;
    rsp_valid_next = '0;
    rsp_data_next  = rsp_data_reg;
    unit_data_next = unit_data_reg;
    rc_ready_next  = rc_ready_reg;

    case (state_reg)
      IDLE: begin
        // Reconfiguration wins over pending work; nothing is in flight here.
        if (bus.rc_req) begin
          state_next     = RECONFIG;
          rc_ready_next  = 1'b1;
          unit_data_next = '0;
        end else if (win_found) begin
          grant_next[win_idx] = 1'b1;
          unit_data_next      = operand[win_idx];
          tag_next            = win_idx;
          ptr_next            = win_idx;
          cnt_next            = CNT_W'(LATENCY);
          state_next          = BUSY;
        end
      end

      BUSY: begin
        // Wait out the unit latency, then hand the result to its owner.
        if (cnt_reg != '0) begin
          cnt_next = cnt_reg - 1'b1;
        end else begin
          rsp_data_next           = bus.unit_result;
          rsp_valid_next[tag_reg] = 1'b1;
          state_next              = IDLE;
        end
      end

      RECONFIG: begin
        // Unit isolated: operand bus held at zero, results ignored.
        unit_data_next = '0;
        rc_ready_next  = 1'b1;
        if (bus.rc_done) begin
          rc_ready_next = 1'b0;
          state_next    = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and output registers; reset drops any in-flight operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      ptr_reg       <= IDX_W'(NUM_REQ - 1);
      tag_reg       <= '0;
      cnt_reg       <= '0;
      grant_reg     <= '0;
      rsp_valid_reg <= '0;
      rsp_data_reg  <= '0;
      unit_data_reg <= '0;
      rc_ready_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      ptr_reg       <= ptr_next;
      tag_reg       <= tag_next;
      cnt_reg       <= cnt_next;
      grant_reg     <= grant_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_data_reg  <= rsp_data_next;
      unit_data_reg <= unit_data_next;
      rc_ready_reg  <= rc_ready_next;
    end
  end

  assign bus.grant     = grant_reg;
  assign bus.rsp_valid = rsp_valid_reg;
  assign bus.rsp_data  = rsp_data_reg;
  assign bus.unit_data = unit_data_reg;
  assign bus.rc_ready  = rc_ready_reg;

endmodule

// File: tb/tb_rr_arith_scheduler.sv
// Bench for rr_arith_scheduler: table of single operations, hand-written
// reconfiguration/reset/fairness sequences, and a randomized run checked
// against a transaction-level reference model. The arithmetic unit is a
// registered decrementer.
module tb_rr_arith_scheduler;

  localparam int N   = 4;
  localparam int W   = 4;
  localparam int LAT = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rr_arith_if #(.NUM_REQ(N), .DATA_W(W)) bus ();

  rr_arith_scheduler #(.NUM_REQ(N), .DATA_W(W), .LATENCY(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Registered decrementer standing in for the reconfigurable unit.
  always @(posedge clk) bus.unit_result <= bus.unit_data - W'(1);

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          idx;
    logic [W-1:0] data;
    logic [W-1:0] exp;
  } vec_t;

  typedef struct {
    int          due;
    int          tag;
    logic [W-1:0] d;
  } exp_t;

  vec_t vecs[6];
  exp_t q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [W-1:0] d);
    bus.req[i] = v;
    bus.req_data[i*W +: W] = d;
  endtask

  task automatic clear_inputs();
    bus.req      = '0;
    bus.req_data = '0;
    bus.rc_req   = 1'b0;
    bus.rc_done  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    step();
    step();
    rst = 1'b0;
  endtask

  // Global guard so the run can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int         last, next_free, w;
    logic [N-1:0] cur_req, exp_grant, exp_rsp;
    logic [W-1:0] cur_data [N];
    logic         pending [N];

    vecs[0] = '{0, 4'd5,  4'd4};
    vecs[1] = '{2, 4'd0,  4'd15};
    vecs[2] = '{1, 4'd9,  4'd8};
    vecs[3] = '{3, 4'd15, 4'd14};
    vecs[4] = '{0, 4'd1,  4'd0};
    vecs[5] = '{2, 4'd10, 4'd9};

    // ---------------- reset state ----------------
    do_reset();
    chk("reset grant",     32'(bus.grant),     0);
    chk("reset rsp_valid", 32'(bus.rsp_valid), 0);
    chk("reset rsp_data",  32'(bus.rsp_data),  0);
    chk("reset unit_data", 32'(bus.unit_data), 0);
    chk("reset rc_ready",  32'(bus.rc_ready),  0);

    // rc_done outside RECONFIG has no effect
    bus.rc_done = 1'b1;
    step();
    bus.rc_done = 1'b0;
    chk("stray rc_done rc_ready", 32'(bus.rc_ready), 0);
    chk("stray rc_done grant",    32'(bus.grant),    0);

    // ---------------- table of single operations ----------------
    for (int v = 0; v < 6; v++) begin
      set_req(vecs[v].idx, 1'b1, vecs[v].data);
      step();
      chk("vec grant",     32'(bus.grant),     32'(1 << vecs[v].idx));
      chk("vec unit_data", 32'(bus.unit_data), 32'(vecs[v].data));
      set_req(vecs[v].idx, 1'b0, '0);
      step();
      chk("vec gap grant", 32'(bus.grant),     0);
      chk("vec gap rsp",   32'(bus.rsp_valid), 0);
      step();
      chk("vec rsp_valid", 32'(bus.rsp_valid), 32'(1 << vecs[v].idx));
      chk("vec rsp_data",  32'(bus.rsp_data),  32'(vecs[v].exp));
      $display("vec %0d: req%0d data=%0h rsp=%0h", v, vecs[v].idx, vecs[v].data, bus.rsp_data);
    end

    // ---------------- round-robin fairness ----------------
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 1'b1, W'(i + 1));
    for (int k = 0; k < 5; k++) begin
      w = k % N;
      step();
      chk("rr grant",     32'(bus.grant),     32'(1 << w));
      chk("rr unit_data", 32'(bus.unit_data), 32'(w + 1));
      step();
      chk("rr gap grant", 32'(bus.grant),     0);
      step();
      chk("rr rsp_valid", 32'(bus.rsp_valid), 32'(1 << w));
      chk("rr rsp_data",  32'(bus.rsp_data),  32'(w));
      chk("rr rsp grant", 32'(bus.grant),     0);
      $display("rr op %0d: granted req%0d rsp=%0h", k, w, bus.rsp_data);
    end
    clear_inputs();

    // ---------------- reconfig requested during BUSY ----------------
    do_reset();
    set_req(1, 1'b1, 4'd9);
    step();
    chk("rcb grant", 32'(bus.grant), 32'b0010);
    set_req(1, 1'b0, '0);
    bus.rc_req = 1'b1;
    step();
    chk("rcb busy rc_ready", 32'(bus.rc_ready), 0);
    step();
    chk("rcb rsp_valid", 32'(bus.rsp_valid), 32'b0010);
    chk("rcb rsp_data",  32'(bus.rsp_data),  8);
    chk("rcb rsp rc_ready", 32'(bus.rc_ready), 0);
    step();
    chk("rcb rc_ready",  32'(bus.rc_ready),  1);
    chk("rcb unit_data", 32'(bus.unit_data), 0);
    bus.rc_req = 1'b0;
    set_req(0, 1'b1, 4'd7);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("rcb hold grant",    32'(bus.grant),    0);
      chk("rcb hold rc_ready", 32'(bus.rc_ready), 1);
    end
    bus.rc_done = 1'b1;
    step();
    bus.rc_done = 1'b0;
    chk("rcb done rc_ready", 32'(bus.rc_ready), 0);
    chk("rcb done grant",    32'(bus.grant),    0);
    step();
    chk("rcb resume grant",     32'(bus.grant),     32'b0001);
    chk("rcb resume unit_data", 32'(bus.unit_data), 7);
    set_req(0, 1'b0, '0);
    step();
    step();
    chk("rcb resume rsp_valid", 32'(bus.rsp_valid), 32'b0001);
    chk("rcb resume rsp_data",  32'(bus.rsp_data),  6);
    $display("reconfig during busy: sequence complete");

    // ---------------- rc_req held across rc_done re-enters ----------------
    bus.rc_req = 1'b1;
    step();
    chk("reenter rc_ready 1", 32'(bus.rc_ready), 1);
    bus.rc_done = 1'b1;
    step();
    bus.rc_done = 1'b0;
    chk("reenter rc_ready 0", 32'(bus.rc_ready), 0);
    step();
    chk("reenter rc_ready again", 32'(bus.rc_ready), 1);
    bus.rc_req  = 1'b0;
    bus.rc_done = 1'b1;
    step();
    bus.rc_done = 1'b0;
    chk("reenter exit rc_ready", 32'(bus.rc_ready), 0);

    // ---------------- reset mid-op ----------------
    do_reset();
    set_req(3, 1'b1, 4'd6);
    step();
    chk("rst grant3", 32'(bus.grant), 32'b1000);
    set_req(3, 1'b0, '0);
    rst = 1'b1;
    step();
    chk("rst outputs grant",     32'(bus.grant),     0);
    chk("rst outputs rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rst outputs unit_data", 32'(bus.unit_data), 0);
    chk("rst outputs rsp_data",  32'(bus.rsp_data),  0);
    step();
    chk("rst no rsp", 32'(bus.rsp_valid), 0);
    rst = 1'b0;
    set_req(0, 1'b1, 4'd2);
    set_req(3, 1'b1, 4'd6);
    step();
    chk("rst after grant0", 32'(bus.grant), 32'b0001);
    set_req(0, 1'b0, '0);
    step();
    step();
    chk("rst after rsp0",      32'(bus.rsp_valid), 32'b0001);
    chk("rst after rsp0 data", 32'(bus.rsp_data),  1);
    step();
    chk("rst after grant3", 32'(bus.grant), 32'b1000);
    set_req(3, 1'b0, '0);
    step();
    step();
    chk("rst after rsp3", 32'(bus.rsp_valid), 32'b1000);

    // ---------------- rc_req vs req priority ----------------
    set_req(1, 1'b1, 4'd3);
    bus.rc_req = 1'b1;
    step();
    chk("prio grant",    32'(bus.grant),    0);
    chk("prio rc_ready", 32'(bus.rc_ready), 1);
    bus.rc_req = 1'b0;
    step();
    chk("prio hold grant", 32'(bus.grant), 0);
    bus.rc_done = 1'b1;
    step();
    bus.rc_done = 1'b0;
    chk("prio done grant", 32'(bus.grant), 0);
    step();
    chk("prio late grant", 32'(bus.grant), 32'b0010);
    set_req(1, 1'b0, '0);
    step();
    step();
    chk("prio rsp_valid", 32'(bus.rsp_valid), 32'b0010);
    chk("prio rsp_data",  32'(bus.rsp_data),  2);

    // ---------------- randomized run vs reference model ----------------
    do_reset();
    last      = N - 1;
    next_free = 0;
    q.delete();
    for (int i = 0; i < N; i++) begin
      pending[i]  = 1'b0;
      cur_data[i] = '0;
    end
    for (int n = 0; n < 400; n++) begin
      // Requesters: raise with random operand, hold until granted, sometimes withdraw.
      for (int i = 0; i < N; i++) begin
        if (!pending[i] && n < 380 && $urandom_range(0, 3) == 0) begin
          pending[i]  = 1'b1;
          cur_data[i] = W'($urandom_range(0, (1 << W) - 1));
        end else if (pending[i] && $urandom_range(0, 15) == 0) begin
          pending[i] = 1'b0;
        end
        set_req(i, pending[i], cur_data[i]);
        cur_req[i] = pending[i];
      end
      step();

      // Reference: unit is free LAT+2 edges after a grant; winner is the first
      // requester after the last winner; result arrives LAT+1 edges later.
      exp_grant = '0;
      w = -1;
      if (n >= next_free && cur_req != '0) begin
        for (int k = 1; k <= N && w < 0; k++) begin
          if (cur_req[(last + k) % N]) w = (last + k) % N;
        end
        exp_grant[w] = 1'b1;
        last      = w;
        next_free = n + LAT + 2;
        q.push_back('{n + LAT + 1, w, cur_data[w] - W'(1)});
      end
      chk("rand grant", 32'(bus.grant), 32'(exp_grant));
      if (w >= 0) begin
        chk("rand unit_data", 32'(bus.unit_data), 32'(cur_data[w]));
        pending[w] = 1'b0;
      end

      exp_rsp = '0;
      if (q.size() > 0 && q[0].due == n) begin
        exp_rsp[q[0].tag] = 1'b1;
        chk("rand rsp_data", 32'(bus.rsp_data), 32'(q[0].d));
        void'(q.pop_front());
      end
      chk("rand rsp_valid", 32'(bus.rsp_valid), 32'(exp_rsp));
    end
    chk("rand drained", 32'(q.size()), 0);
    $display("random run: 400 cycles complete");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
